// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 classic data RAM responder with programmable wait states,
// byte-lane writes and error termination for misaligned, out-of-window or empty-select accesses.
`default_nettype none

module wb_ram_slave #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [32:0] C_SPAN = 33'd1 << (ADDR_WIDTH + 2);
   localparam logic [3:0]  C_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  we_q, we_d;
   logic [3:0]            sel_q, sel_d;
   logic [31:0]           wdat_q, wdat_d;
   logic [31:0]           rdat_q, rdat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [31:0]           mem_q [DEPTH];

   logic [32:0]           w_diff;
   logic                  w_bad;
   logic                  w_commit;

   // A borrow out of the 33-bit subtraction lands above C_SPAN, so one compare covers both bounds.
   always_comb begin
      w_diff = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
      w_bad  = (wb_adr_i[1:0] != 2'b00) || (w_diff >= C_SPAN) || (wb_sel_i == 4'b0000);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      we_d     = we_q;
      sel_d    = sel_q;
      wdat_d   = wdat_q;
      w_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               idx_d  = w_diff[ADDR_WIDTH+1:2];
               we_d   = wb_we_i;
               sel_d  = wb_sel_i;
               wdat_d = wb_dat_i;
               if (w_bad) begin
                  state_d = S_ERR;
               end else if (WAIT_CYCLES == 0) begin
                  state_d  = S_ACK;
                  w_commit = 1'b1;
               end else begin
                  cnt_d   = C_LOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d  = S_ACK;
               w_commit = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ack_d  = w_commit;
      err_d  = (state_d == S_ERR);
      rdat_d = (w_commit && !we_d) ? mem_q[idx_d] : 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         wdat_q  <= 32'd0;
         rdat_q  <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // RAM is never cleared; rst only blocks a commit that would coincide with it.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && we_d) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_d[b]) begin
               mem_q[idx_d][8*b +: 8] <= wdat_d[8*b +: 8];
            end
         end
      end
   end

   assign wb_dat_o = rdat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;

endmodule

`default_nettype wire
